serial_adder_n: RTL
===================

Name: serial_adder_n

Overview:
Multi-cycle, parametrised successor to the 1-bit full adder. Adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock through an internal DIGIT-bit full-adder slice and a registered carry. Uses a start/busy/done handshake. Sits beside the combinational adders where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A, captured on the accepting edge
b  input  WIDTH  operand B, captured on the accepting edge
c  input  1  carry-in, captured on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  result; held until the next accepted start
carry  output  1  carry-out of the MSB; held with sum
overflow  output  1  signed overflow: carry into MSB XOR carry-out; held with sum

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at an edge): state goes to IDLE. busy, done, sum, carry, overflow and the internal operand, carry and count registers all go to 0. Reset wins over every other event, including mid-RUN; any partial result is discarded.
- Let N = WIDTH/DIGIT.
- States:
  - IDLE: busy=0, done=0. On start=1, capture a, b and c into internal registers, clear the step counter and go to RUN.
  - RUN: busy=1. At each edge, add the lowest unprocessed DIGIT-bit chunk of a and b plus the registered carry. Write the chunk sum into the matching bit position of sum and update the carry register. After the N-th step, go to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle. On start=1, capture new operands and go to RUN (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: start accepted at edge k; done=1 during the cycle after edge k+N. With DIGIT=WIDTH, done follows one cycle after acceptance.
- start during RUN is ignored. Operands are not recaptured and the counter is not disturbed.
- Changes on a, b or c after acceptance have no effect on the result.
- sum, carry and overflow update only at the completion of the final step. The bit-write into sum is internal, and outputs present the completed result; sum may be driven from the working register provided it is not observable as changed before done. Values persist through IDLE until the next accepted start.
- Arithmetic is modulo 2^WIDTH. carry equals bit WIDTH of the full sum a+b+c.
- overflow is computed from the carry into bit WIDTH-1 and the final carry.
- WIDTH=1, DIGIT=1 behaves as the registered full adder: sum = a^b^c, carry = majority(a,b,c).

Optional Feature:
SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), captured with the operands. sub=1 computes a + ~b + ~c, i.e. a - b - c. In that case carry=1 means no borrow and overflow is signed subtraction overflow. sub=0 behaves as the add path.
- Undefined: no sub port; add only. Timing and handshake are identical in both builds.

Test Plan:
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, c=0, start at edge k -> busy high for 8 cycles, done pulse after edge k+8, sum=0x00, carry=1, overflow=0.
- WIDTH=8, DIGIT=4: a=0x7F, b=0x01, c=0 -> done after edge k+2, sum=0x80, carry=0, overflow=1. Then a=0x80, b=0x80, c=1 -> sum=0x01, carry=1, overflow=1.
- Start held high during RUN with different operands -> ignored; first result still reported. Start asserted in the DONE cycle -> new RUN begins immediately, second done exactly N cycles later.
- rst_n=0 for one edge in step 3 of an 8-step RUN -> next cycle IDLE, all outputs 0. A new start then yields the correct result with no carry contamination.
- Exhaustive WIDTH=1 sweep over all 8 (a,b,c) combinations -> sum/carry match the full-adder truth table, done one cycle after each acceptance.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8: sub=1, a=0x05, b=0x07, c=0 -> sum=0xFE, carry=0, overflow=0. sub=1, a=0x80, b=0x01, c=0 -> sum=0x7F, carry=1, overflow=1.

Source files
------------

// File: rtl/serial_adder_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : serial_adder_n                                             |
// | Description : Multi-cycle WIDTH-bit adder processing DIGIT bits per      |
// |               clock through a DIGIT-bit slice with a registered carry.   |
// |               start/busy/done handshake; result held until next start.   |
// |               Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that |
// |               selects a - b - c.                                         |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int                 C_STEPS = WIDTH / DIGIT;
  localparam int                 C_CNT_W = (C_STEPS > 1) ? $clog2(C_STEPS) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(C_STEPS - 1);
  localparam logic [DIGIT-1:0]   C_ONES  = '1;
  localparam logic [WIDTH-1:0]   C_MASK  = WIDTH'(C_ONES);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_n: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cy;
  logic [C_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_overflow;

  logic [WIDTH-1:0]   w_b_in;
  logic               w_c_in;
  logic               w_accept;
  logic [31:0]        w_shamt;
  logic [DIGIT-1:0]   w_chunk_a;
  logic [DIGIT-1:0]   w_chunk_b;
  logic [DIGIT:0]     w_add;
  logic [DIGIT-1:0]   w_chunk_sum;
  logic [WIDTH-1:0]   w_work_next;
  logic               w_ov_step;

  // Subtraction is folded into capture: a - b - c == a + ~b + ~c.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? ~c : c;
`else
  assign w_b_in = b;
  assign w_c_in = c;
`endif

  // New operands are only taken when no run is in flight.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Current digit position selected by the step counter.
  assign w_shamt     = 32'(r_cnt) * 32'(DIGIT);
  assign w_chunk_a   = DIGIT'(r_a >> w_shamt);
  assign w_chunk_b   = DIGIT'(r_b >> w_shamt);
  assign w_add       = {1'b0, w_chunk_a} + {1'b0, w_chunk_b} + {{DIGIT{1'b0}}, r_cy};
  assign w_chunk_sum = w_add[DIGIT-1:0];
  assign w_work_next = (r_work & ~(C_MASK << w_shamt)) | (WIDTH'(w_chunk_sum) << w_shamt);

  // Carry into the top bit of this digit, recovered from the sum bit; only
  // used on the final step, where the top bit of the digit is the MSB.
  assign w_ov_step = (w_chunk_a[DIGIT-1] ^ w_chunk_b[DIGIT-1] ^ w_chunk_sum[DIGIT-1]) ^ w_add[DIGIT];

  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_overflow;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == C_LAST) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, digit-serial accumulation and result publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_cy       <= 1'b0;
      r_cnt      <= '0;
      r_work     <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= w_b_in;
      r_cy   <= w_c_in;
      r_cnt  <= '0;
      r_work <= '0;
    end else if (r_state == S_RUN) begin
      r_work <= w_work_next;
      r_cy   <= w_add[DIGIT];
      r_cnt  <= r_cnt + C_CNT_W'(1);
      if (r_cnt == C_LAST) begin
        r_sum      <= w_work_next;
        r_carry    <= w_add[DIGIT];
        r_overflow <= w_ov_step;
      end
    end
  end

endmodule
`default_nettype wire
